// File: rtl/addr_decode_prog.sv
// addr_decode_prog
//   Registered, runtime-programmable address decoder. A table of RuleNum
//   rules (start, end/mask, slave select, enable) is written through the cfg_*
//   port. Each accepted request is matched against the current table. The
//   resulting slave index, tag and status leave through a one-stage
//   valid/ready output register.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/cfg_idx      rule write strobe and entry index (idx >= RuleNum ignored)
//   cfg_start/cfg_end   rule start and exclusive end (range) or mask (NAPOT)
//   cfg_sel/cfg_en      rule slave index and enable
//   cnt_clr             clears err_cnt (wins over a same-cycle increment)
//   in_valid/in_ready   request handshake; in_addr/in_id request payload
//   out_valid/out_ready result handshake
//   out_sel/out_id      selected slave index and request tag
//   out_hit/out_multi   any / more than one enabled rule matched
//   out_err             no rule matched and no default route
//   err_cnt             saturating count of accepted requests with out_err=1
module addr_decode_prog #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned IdxWidth   = 3,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned RuleNum    = 8,
  parameter int unsigned Napot      = 0,
  parameter int unsigned DefaultEn  = 0,
  parameter int unsigned DefaultIdx = 0
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               cfg_we,
  input  logic [((RuleNum > 1) ? $clog2(RuleNum) : 1)-1:0]   cfg_idx,
  input  logic [AddrWidth-1:0]                               cfg_start,
  input  logic [AddrWidth-1:0]                               cfg_end,
  input  logic [IdxWidth-1:0]                                cfg_sel,
  input  logic                                               cfg_en,
  input  logic                                               cnt_clr,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [AddrWidth-1:0]                               in_addr,
  input  logic [IdWidth-1:0]                                 in_id,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [IdxWidth-1:0]                                out_sel,
  output logic [IdWidth-1:0]                                 out_id,
  output logic                                               out_hit,
  output logic                                               out_multi,
  output logic                                               out_err,
  output logic [15:0]                                        err_cnt
);

  logic [AddrWidth-1:0] r_start [RuleNum];
  logic [AddrWidth-1:0] r_end   [RuleNum];
  logic [IdxWidth-1:0]  r_sel   [RuleNum];
  logic [RuleNum-1:0]   r_en;

  logic [RuleNum-1:0]   match;
  logic                 dec_hit;
  logic                 dec_multi;
  logic                 dec_err;
  logic [IdxWidth-1:0]  dec_sel;
  logic                 accept;

  // Rule table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RuleNum; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_sel[i]   <= '0;
      end
      r_en <= '0;
    end else if (cfg_we && (int'(cfg_idx) < int'(RuleNum))) begin
      r_start[cfg_idx] <= cfg_start;
      r_end[cfg_idx]   <= cfg_end;
      r_sel[cfg_idx]   <= cfg_sel;
      r_en[cfg_idx]    <= cfg_en;
    end
  end

  // Per-rule match against the table as it stands before this edge, so a
  // same-cycle config write never affects the request being accepted.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < RuleNum; i++) begin
      if (Napot != 0) begin
        match[i] = r_en[i] && ((in_addr & r_end[i]) == (r_start[i] & r_end[i]));
      end else begin
        match[i] = r_en[i] && (in_addr >= r_start[i]) && (in_addr < r_end[i]);
      end
    end
  end

  // Ascending scan: the last matching entry (highest index) wins.
  always_comb begin
    dec_hit   = 1'b0;
    dec_multi = 1'b0;
    dec_sel   = '0;
    for (int unsigned i = 0; i < RuleNum; i++) begin
      if (match[i]) begin
        dec_multi = dec_multi | dec_hit;
        dec_hit   = 1'b1;
        dec_sel   = r_sel[i];
      end
    end
    if (!dec_hit && (DefaultEn != 0)) begin
      dec_sel = IdxWidth'(DefaultIdx);
    end
    dec_err = !dec_hit && (DefaultEn == 0);
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output stage: fields only load on accept, so they hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_id    <= '0;
      out_hit   <= 1'b0;
      out_multi <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sel   <= dec_sel;
      out_id    <= in_id;
      out_hit   <= dec_hit;
      out_multi <= dec_multi;
      out_err   <= dec_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (accept && dec_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_addr_decode_prog.sv
// Bench for addr_decode_prog. Three instances share one stimulus stream:
//   0: range rules, no default   1: NAPOT rules, no default
//   2: range rules, default route to slave 6
module tb_addr_decode_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_en, cnt_clr, in_valid, out_ready;
  logic [2:0]  cfg_idx, cfg_sel;
  logic [31:0] cfg_start, cfg_end, in_addr;
  logic [3:0]  in_id;

  logic        d_ready [3];
  logic        d_valid [3];
  logic [2:0]  d_sel   [3];
  logic [3:0]  d_id    [3];
  logic        d_hit   [3];
  logic        d_multi [3];
  logic        d_err   [3];
  logic [15:0] d_cnt   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addr_decode_prog #(.AddrWidth(32), .IdxWidth(3), .IdWidth(4), .RuleNum(8),
                     .Napot(0), .DefaultEn(0), .DefaultIdx(0)) u_rng (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cnt_clr(cnt_clr), .in_valid(in_valid), .in_ready(d_ready[0]),
    .in_addr(in_addr), .in_id(in_id), .out_valid(d_valid[0]), .out_ready(out_ready),
    .out_sel(d_sel[0]), .out_id(d_id[0]), .out_hit(d_hit[0]), .out_multi(d_multi[0]),
    .out_err(d_err[0]), .err_cnt(d_cnt[0]));

  addr_decode_prog #(.AddrWidth(32), .IdxWidth(3), .IdWidth(4), .RuleNum(8),
                     .Napot(1), .DefaultEn(0), .DefaultIdx(0)) u_nap (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cnt_clr(cnt_clr), .in_valid(in_valid), .in_ready(d_ready[1]),
    .in_addr(in_addr), .in_id(in_id), .out_valid(d_valid[1]), .out_ready(out_ready),
    .out_sel(d_sel[1]), .out_id(d_id[1]), .out_hit(d_hit[1]), .out_multi(d_multi[1]),
    .out_err(d_err[1]), .err_cnt(d_cnt[1]));

  addr_decode_prog #(.AddrWidth(32), .IdxWidth(3), .IdWidth(4), .RuleNum(8),
                     .Napot(0), .DefaultEn(1), .DefaultIdx(6)) u_def (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cnt_clr(cnt_clr), .in_valid(in_valid), .in_ready(d_ready[2]),
    .in_addr(in_addr), .in_id(in_id), .out_valid(d_valid[2]), .out_ready(out_ready),
    .out_sel(d_sel[2]), .out_id(d_id[2]), .out_hit(d_hit[2]), .out_multi(d_multi[2]),
    .out_err(d_err[2]), .err_cnt(d_cnt[2]));

  // ---------------- behavioural model ----------------
  int          k_napot  [3] = '{0, 1, 0};
  int          k_defen  [3] = '{0, 0, 1};
  int          k_defidx [3] = '{0, 0, 6};

  logic [31:0] m_start [8];
  logic [31:0] m_end   [8];
  logic [2:0]  m_sel   [8];
  logic        m_en    [8];

  logic        e_valid;
  logic [2:0]  e_sel   [3];
  logic [3:0]  e_id;
  logic        e_hit   [3];
  logic        e_multi [3];
  logic        e_err   [3];
  int          e_cnt   [3];

  function automatic void decode(input logic [31:0] a, input int k,
                                 output logic [2:0] sel, output logic hit,
                                 output logic multi, output logic err);
    int n = 0;
    int last = 0;
    bit m;
    for (int i = 0; i < 8; i++) begin
      if (k_napot[k] != 0) m = ((a & m_end[i]) == (m_start[i] & m_end[i]));
      else                 m = (a >= m_start[i]) && (a < m_end[i]);
      if (m_en[i] && m) begin
        n++;
        last = i;
      end
    end
    hit   = (n > 0);
    multi = (n > 1);
    err   = (n == 0) && (k_defen[k] == 0);
    if (n > 0)               sel = m_sel[last];
    else if (k_defen[k] != 0) sel = 3'(k_defidx[k]);
    else                     sel = 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid = 1'b0;
      e_id    = '0;
      for (int k = 0; k < 3; k++) begin
        e_sel[k] = '0; e_hit[k] = 0; e_multi[k] = 0; e_err[k] = 0; e_cnt[k] = 0;
      end
      for (int i = 0; i < 8; i++) begin
        m_start[i] = '0; m_end[i] = '0; m_sel[i] = '0; m_en[i] = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && (!e_valid || out_ready);
      for (int k = 0; k < 3; k++) begin
        if (acc) decode(in_addr, k, e_sel[k], e_hit[k], e_multi[k], e_err[k]);
        if (cnt_clr)                            e_cnt[k] = 0;
        else if (acc && e_err[k] && e_cnt[k] < 65535) e_cnt[k] = e_cnt[k] + 1;
      end
      if (acc) begin
        e_valid = 1'b1;
        e_id    = in_id;
      end else if (out_ready) begin
        e_valid = 1'b0;
      end
      if (cfg_we) begin
        m_start[cfg_idx] = cfg_start;
        m_end[cfg_idx]   = cfg_end;
        m_sel[cfg_idx]   = cfg_sel;
        m_en[cfg_idx]    = cfg_en;
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input int k, input logic [31:0] dut,
                     input logic [31:0] mdl, input logic [31:0] exp);
    chk(name, k, dut, exp);
    chk({name, "_model"}, k, mdl, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk("out_valid", k, 32'(d_valid[k]), 32'(e_valid));
        chk("in_ready", k, 32'(d_ready[k]), 32'(!e_valid || out_ready));
        chk("err_cnt", k, 32'(d_cnt[k]), 32'(e_cnt[k]));
        if (e_valid) begin
          chk("out_sel", k, 32'(d_sel[k]), 32'(e_sel[k]));
          chk("out_id", k, 32'(d_id[k]), 32'(e_id));
          chk("out_hit", k, 32'(d_hit[k]), 32'(e_hit[k]));
          chk("out_multi", k, 32'(d_multi[k]), 32'(e_multi[k]));
          chk("out_err", k, 32'(d_err[k]), 32'(e_err[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] s, input logic [31:0] e,
                    input logic [2:0] sel, input logic en);
    cfg_idx = idx; cfg_start = s; cfg_end = e; cfg_sel = sel; cfg_en = en;
    cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] id);
    in_addr = a; in_id = id; in_valid = 1'b1;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_en = 0; cnt_clr = 0; in_valid = 0; out_ready = 1;
    cfg_idx = '0; cfg_sel = '0; cfg_start = '0; cfg_end = '0; in_addr = '0; in_id = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      lit("rst_valid", k, 32'(d_valid[k]), 32'(e_valid), 0);
      lit("rst_cnt", k, 32'(d_cnt[k]), 32'(e_cnt[k]), 0);
      lit("rst_sel", k, 32'(d_sel[k]), 32'(e_sel[k]), 0);
      lit("rst_err", k, 32'(d_err[k]), 32'(e_err[k]), 0);
    end

    // Range boundaries
    wr(0, 32'h1000, 32'h2000, 3'd2, 1'b1);
    send(32'h0FFF, 4'd1);
    lit("r_err_below", 0, 32'(d_err[0]), 32'(e_err[0]), 1);
    lit("r_sel_below", 0, 32'(d_sel[0]), 32'(e_sel[0]), 0);
    send(32'h1000, 4'd2);
    lit("r_hit_start", 0, 32'(d_hit[0]), 32'(e_hit[0]), 1);
    lit("r_sel_start", 0, 32'(d_sel[0]), 32'(e_sel[0]), 2);
    send(32'h1FFF, 4'd3);
    lit("r_sel_last", 0, 32'(d_sel[0]), 32'(e_sel[0]), 2);
    send(32'h2000, 4'd4);
    lit("r_err_end", 0, 32'(d_err[0]), 32'(e_err[0]), 1);
    lit("r_cnt", 0, 32'(d_cnt[0]), 32'(e_cnt[0]), 2);
    idle();

    // Overlapping rules
    wr(1, 32'h0, 32'h10000, 3'd1, 1'b1);
    wr(5, 32'h1000, 32'h1100, 3'd5, 1'b1);
    send(32'h1080, 4'd5);
    lit("ov_sel", 0, 32'(d_sel[0]), 32'(e_sel[0]), 5);
    lit("ov_multi", 0, 32'(d_multi[0]), 32'(e_multi[0]), 1);
    send(32'h3000, 4'd6);
    lit("ov_sel1", 0, 32'(d_sel[0]), 32'(e_sel[0]), 1);
    lit("ov_multi0", 0, 32'(d_multi[0]), 32'(e_multi[0]), 0);
    idle();

    // NAPOT
    wr(1, 32'h0, 32'h0, 3'd0, 1'b0);
    wr(5, 32'h0, 32'h0, 3'd0, 1'b0);
    wr(0, 32'h4000_0000, 32'hF000_0000, 3'd3, 1'b1);
    send(32'h4ABC_0000, 4'd7);
    lit("n_sel", 1, 32'(d_sel[1]), 32'(e_sel[1]), 3);
    lit("n_hit", 1, 32'(d_hit[1]), 32'(e_hit[1]), 1);
    send(32'h5000_0000, 4'd8);
    lit("n_err", 1, 32'(d_err[1]), 32'(e_err[1]), 1);
    lit("n_hit0", 1, 32'(d_hit[1]), 32'(e_hit[1]), 0);
    idle();

    // Write and accept in the same cycle: request sees the old table
    cfg_idx = 3'd2; cfg_start = 32'h8000_0000; cfg_end = 32'h9000_0000;
    cfg_sel = 3'd4; cfg_en = 1'b1; cfg_we = 1'b1;
    send(32'h8000_0010, 4'd9);
    cfg_we = 1'b0;
    lit("old_tbl_sel", 0, 32'(d_sel[0]), 32'(e_sel[0]), 3);
    lit("old_tbl_multi", 0, 32'(d_multi[0]), 32'(e_multi[0]), 0);
    send(32'h8000_0010, 4'd10);
    lit("new_tbl_sel", 0, 32'(d_sel[0]), 32'(e_sel[0]), 4);
    lit("new_tbl_multi", 0, 32'(d_multi[0]), 32'(e_multi[0]), 1);
    idle();
    wr(2, 32'h0, 32'h0, 3'd0, 1'b0);

    // Backpressure with a rule rewrite during the stall
    out_ready = 1'b0;
    send(32'h4ABC_0000, 4'd1);
    in_addr = 32'h5000_0000; in_id = 4'd2;
    for (int i = 0; i < 4; i++) begin
      lit("bp_ready", 1, 32'(d_ready[1]), 32'(!e_valid || out_ready), 0);
      lit("bp_sel", 1, 32'(d_sel[1]), 32'(e_sel[1]), 3);
      lit("bp_hit", 1, 32'(d_hit[1]), 32'(e_hit[1]), 1);
      lit("bp_id", 1, 32'(d_id[1]), 32'(e_id), 1);
      if (i == 1) begin
        cfg_idx = 3'd0; cfg_start = '0; cfg_end = '0; cfg_sel = '0; cfg_en = 1'b0;
        cfg_we = 1'b1;
      end
      cyc();
      cfg_we = 1'b0;
    end
    lit("bp_sel_after_wr", 1, 32'(d_sel[1]), 32'(e_sel[1]), 3);
    out_ready = 1'b1;
    #1;
    lit("bp_release_ready", 1, 32'(d_ready[1]), 32'(!e_valid || out_ready), 1);
    cyc();
    lit("bp_next_id", 1, 32'(d_id[1]), 32'(e_id), 2);
    lit("bp_next_err", 1, 32'(d_err[1]), 32'(e_err[1]), 1);

    // Default route (all rules disabled)
    send(32'hDEAD_BEEF, 4'd11);
    lit("def_sel", 2, 32'(d_sel[2]), 32'(e_sel[2]), 6);
    lit("def_hit", 2, 32'(d_hit[2]), 32'(e_hit[2]), 0);
    lit("def_err", 2, 32'(d_err[2]), 32'(e_err[2]), 0);
    lit("def_cnt", 2, 32'(d_cnt[2]), 32'(e_cnt[2]), 0);
    idle();

    // Saturation
    in_addr = 32'h5000_0000; in_id = 4'd3; in_valid = 1'b1;
    repeat (65537) cyc();
    lit("sat_cnt", 0, 32'(d_cnt[0]), 32'(e_cnt[0]), 32'hFFFF);
    lit("sat_cnt", 1, 32'(d_cnt[1]), 32'(e_cnt[1]), 32'hFFFF);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    lit("clr_cnt", 0, 32'(d_cnt[0]), 32'(e_cnt[0]), 0);

    // Async reset mid-stream
    wr(0, 32'h0, 32'hFFFF_FFFF, 3'd1, 1'b1);
    cyc();
    lit("pre_rst_hit", 0, 32'(d_hit[0]), 32'(e_hit[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      lit("async_rst_valid", k, 32'(d_valid[k]), 32'(e_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    lit("post_rst_err", 0, 32'(d_err[0]), 32'(e_err[0]), 1);
    lit("post_rst_hit", 0, 32'(d_hit[0]), 32'(e_hit[0]), 0);
    lit("post_rst_cnt", 0, 32'(d_cnt[0]), 32'(e_cnt[0]), 1);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_decode_prog.md
Name: addr_decode_prog

Overview:
- Registered, runtime-programmable address decoder that maps a request address to a slave index.
- Rule table is written through a config port; each rule is enabled individually.
- Decode result leaves through a one-stage valid/ready pipeline register.
- Sits between a master-side request channel and the crossbar select logic. Replaces static compile-time maps wherever firmware must remap slaves.

Parameters:
AddrWidth, 32, request/rule address width
IdxWidth, 3, slave index width
IdWidth, 4, passthrough request tag width
RuleNum, 8, number of rule entries (>=1)
Napot, 0, 0 = range rules, 1 = NAPOT rules (end field is a mask)
DefaultEn, 0, 1 = unmatched addresses route to DefaultIdx without error
DefaultIdx, 0, slave index used when DefaultEn=1 and no rule hits

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  rule write strobe
cfg_idx  in  max(1,$clog2(RuleNum))  rule entry written; values >= RuleNum ignored
cfg_start  in  AddrWidth  rule start address
cfg_end  in  AddrWidth  range end (exclusive) or NAPOT mask
cfg_sel  in  IdxWidth  slave index for rule
cfg_en  in  1  rule enable
cnt_clr  in  1  clears err_cnt
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_addr  in  AddrWidth  request address
in_id  in  IdWidth  request tag
out_valid  out  1  decode result valid
out_ready  in  1  downstream accepts result
out_sel  out  IdxWidth  selected slave index
out_id  out  IdWidth  tag of decoded request
out_hit  out  1  at least one enabled rule matched
out_multi  out  1  more than one enabled rule matched
out_err  out  1  decode error (no hit, DefaultEn=0)
err_cnt  out  16  saturating count of accepted requests decoded with out_err=1

Behaviour:
- Reset (async assert, sync-release usage): out_valid=0; out_sel/out_id/out_hit/out_multi/out_err=0; all rules start=end=sel=0, en=0; err_cnt=0.
- Config: cfg_we with cfg_idx<RuleNum writes {start,end,sel,en} at the edge. The entry is used from the next cycle. A request accepted in the same cycle as a write decodes with the old table.
- Match, range mode: en & (addr>=start) & (addr<end), unsigned compare. start>=end never matches.
- Match, NAPOT mode: en & ((addr&mask)==(start&mask)). mask=0 matches all addresses.
- Priority: on multiple hits the highest rule index wins; out_multi=1.
- No hit with DefaultEn=1: sel=DefaultIdx, hit=0, err=0.
- No hit with DefaultEn=0: sel=0, hit=0, err=1.
- Pipeline: in_ready = !out_valid | out_ready (combinational from out_ready).
  - Accept: result fields and id load at the edge; out_valid=1. Latency is exactly 1 cycle.
  - Full throughput (one request per cycle) while out_ready=1.
- Output hold: while out_valid & !out_ready, all out_* fields remain stable. A config write during the stall does not alter the held result.
- Drain: out_valid clears when out_ready=1 and no new request is accepted.
- err_cnt:
  - Increments by 1 per accepted request whose decode has err=1.
  - Saturates at 16'hFFFF.
  - cnt_clr has priority over an increment in the same cycle (result 0).
- Reset mid-transfer drops the held result and the whole table; no request survives.

Test Plan:
- Range mode. Rule0 {0x1000,0x2000,sel 2,en}. Addresses 0x0FFF, 0x1000, 0x1FFF, 0x2000 back-to-back with out_ready=1 -> results one cycle after each accept: err/hit/hit/err, sel 0/2/2/0; err_cnt=2.
- Overlap. Rule1 {0x0,0x10000,sel 1}, rule5 {0x1000,0x1100,sel 5}. Address 0x1080 -> out_sel=5, out_multi=1. Address 0x3000 -> out_sel=1, out_multi=0.
- NAPOT (Napot=1). Rule0 start 0x4000_0000, mask 0xF000_0000, sel 3. Address 0x4ABC_0000 -> sel 3, hit. Address 0x5000_0000 -> err.
- Backpressure. out_ready=0 for 4 cycles with in_valid held -> in_ready=0 after the first accept; outputs stable. Rewrite rule0 during the stall -> held result unchanged. out_ready=1 -> next request accepted that cycle.
- DefaultEn=1, DefaultIdx=6, all rules disabled. Address 0xDEAD_BEEF -> sel 6, hit=0, err=0, err_cnt=0.
- Saturation and clear. Force 65537 erroring requests -> err_cnt=0xFFFF. cnt_clr together with an erroring accept -> err_cnt=0. Async rst_n pulse mid-stream -> out_valid=0 immediately; rules disabled.
